// File: rtl/wb_arb_pkg.sv
// Shared types and helpers for the register-file write-port arbiter.
// A buffered result is a wb_req_t; its vld bit drops when a younger write claims the same rd.
package wb_arb_pkg;

  typedef struct packed {
    logic        vld;
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_req_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // True when a committed write to rd makes the buffered entry stale.
  // Writes to x0 never kill anything because x0 is never written.
  function automatic logic waw_match(input wb_req_t entry, input logic [4:0] rd);
    return entry.vld && (entry.rd == rd) && (rd != REG_ZERO);
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Circular buffer of long-latency results with per-entry kill by destination register.
// Killed entries keep their slot and drain in order; only their vld bit is cleared.
module wb_fifo
  import wb_arb_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_push,
  input  logic [4:0]    i_push_rd,
  input  logic [31:0]   i_push_data,
  input  logic          i_pop,
  input  logic          i_kill,
  input  logic [4:0]    i_kill_rd,
  output logic          o_head_vld,
  output logic [4:0]    o_head_rd,
  output logic [31:0]   o_head_data,
  output logic [CW-1:0] o_count
);

  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  wb_req_t       r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  wb_req_t w_push_req;
  logic    w_push;
  logic    w_pop;
  logic    w_push_killed;

  // A full buffer never accepts, even when the head drains in the same cycle.
  assign w_push        = i_push && (r_count != FULL_CNT);
  assign w_pop         = i_pop && (r_count != '0);
  assign w_push_req    = '{vld: 1'b1, rd: i_push_rd, data: i_push_data};
  assign w_push_killed = i_kill && waw_match(w_push_req, i_kill_rd);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i].vld <= 1'b0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (i_kill && waw_match(r_mem[i], i_kill_rd)) begin
          r_mem[i].vld <= 1'b0;
        end
      end
      // The push slot is never a live entry, so this write cannot race a kill.
      if (w_push) begin
        r_mem[r_wr_ptr] <= '{vld: !w_push_killed, rd: i_push_rd, data: i_push_data};
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head_vld  = r_mem[r_rd_ptr].vld;
  assign o_head_rd   = r_mem[r_rd_ptr].rd;
  assign o_head_data = r_mem[r_rd_ptr].data;
  assign o_count     = r_count;

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the register file write port between the WB stage and buffered long-latency results.
// The pipeline wins by default; a starvation counter periodically forces the buffer head out.
module wb_port_arbiter
  import wb_arb_pkg::*;
#(
  parameter int DEPTH    = 2,
  parameter int MAX_WAIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        W_wb_valid,
  input  logic [4:0]  W_rd_index,
  input  logic [31:0] W_rd_data,
  input  logic        L_valid,
  input  logic [4:0]  L_rd_index,
  input  logic [31:0] L_data,
  output logic        L_ready,
  output logic        stall_pipe,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int WW = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
  localparam logic [WW-1:0] WAIT_MAX = WW'(MAX_WAIT);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WW-1:0] r_wait_cnt;

  logic          w_head_vld;
  logic [4:0]    w_head_rd;
  logic [31:0]   w_head_data;
  logic [CW-1:0] w_count;
  logic          w_empty;
  logic          w_full;
  logic          w_force;
  logic          w_pop;
  logic          w_p_commit;
  logic          w_push;

  // L_valid/L_ready: a result transfers on any cycle both are high; L_ready comes only
  // from registered occupancy, so the producer may hold L_valid without a comb loop.
  assign w_empty = (w_count == '0);
  assign w_full  = (w_count == FULL_CNT);
  assign L_ready = !rst && !w_full;
  assign w_push  = L_valid && L_ready;

  assign w_force    = !w_empty && (r_wait_cnt == WAIT_MAX);
  assign stall_pipe = !rst && w_force && W_wb_valid;
  assign w_pop      = !rst && !w_empty && (w_force || !W_wb_valid);
  assign w_p_commit = !rst && W_wb_valid && !stall_pipe;

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .i_push      (w_push),
    .i_push_rd   (L_rd_index),
    .i_push_data (L_data),
    .i_pop       (w_pop),
    .i_kill      (w_p_commit),
    .i_kill_rd   (W_rd_index),
    .o_head_vld  (w_head_vld),
    .o_head_rd   (w_head_rd),
    .o_head_data (w_head_data),
    .o_count     (w_count)
  );

  // Stale (killed) entries and x0 targets still consume their grant, just without a write.
  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = W_rd_index;
    rf_wdata = W_rd_data;
    if (w_pop) begin
      rf_we    = w_head_vld && (w_head_rd != REG_ZERO);
      rf_waddr = w_head_rd;
      rf_wdata = w_head_data;
    end else if (w_p_commit) begin
      rf_we    = (W_rd_index != REG_ZERO);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wait_cnt <= '0;
    end else if (w_pop) begin
      r_wait_cnt <= '0;
    end else if (!w_empty && w_p_commit && (r_wait_cnt != WAIT_MAX)) begin
      r_wait_cnt <= r_wait_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: directed scenarios plus random traffic against a queue-based model.
module tb_wb_port_arbiter;

  localparam int DEPTH    = 2;
  localparam int MAX_WAIT = 4;

  logic        clk;
  logic        rst;
  logic        W_wb_valid;
  logic [4:0]  W_rd_index;
  logic [31:0] W_rd_data;
  logic        L_valid;
  logic [4:0]  L_rd_index;
  logic [31:0] L_data;
  logic        L_ready;
  logic        stall_pipe;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  wb_port_arbiter #(.DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
    .clk        (clk),
    .rst        (rst),
    .W_wb_valid (W_wb_valid),
    .W_rd_index (W_rd_index),
    .W_rd_data  (W_rd_data),
    .L_valid    (L_valid),
    .L_rd_index (L_rd_index),
    .L_data     (L_data),
    .L_ready    (L_ready),
    .stall_pipe (stall_pipe),
    .rf_we      (rf_we),
    .rf_waddr   (rf_waddr),
    .rf_wdata   (rf_wdata)
  );

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // reference model: ordered list of buffered results and a plain starvation count
  typedef struct {
    bit          live;
    logic [4:0]  rd;
    logic [31:0] data;
  } m_ent_t;

  m_ent_t      mq[$];
  int          m_wait;
  logic [31:0] model_rf [32];
  logic [31:0] dut_rf [32];

  // expected per-cycle outputs: {stall, we, waddr, wdata, l_ready}
  logic [39:0] exp_q[$];
  int          n_cmp;
  int          n_err;
  int          cyc;

  task automatic drive(input logic r, input logic wv, input logic [4:0] wrd,
                       input logic [31:0] wd, input logic lv, input logic [4:0] lrd,
                       input logic [31:0] ld);
    logic        e_stall, e_we, e_lr;
    logic [4:0]  e_addr;
    logic [31:0] e_data;
    bit          popped, commit;
    int          size0;
    m_ent_t      h;
    @(posedge clk);
    #1;
    rst = r; W_wb_valid = wv; W_rd_index = wrd; W_rd_data = wd;
    L_valid = lv; L_rd_index = lrd; L_data = ld;
    e_stall = 1'b0; e_we = 1'b0; e_lr = 1'b0; e_addr = '0; e_data = '0;
    popped = 0; commit = 0;
    if (r) begin
      mq.delete();
      m_wait = 0;
    end else begin
      size0 = mq.size();
      e_lr  = (size0 < DEPTH);
      if (size0 > 0 && m_wait == MAX_WAIT) begin
        h = mq.pop_front(); popped = 1;
        e_stall = wv;
        e_we = h.live && (h.rd != 0); e_addr = h.rd; e_data = h.data;
      end else if (wv) begin
        commit = 1;
        e_we = (wrd != 0); e_addr = wrd; e_data = wd;
        if (wrd != 0) foreach (mq[i]) if (mq[i].rd == wrd) mq[i].live = 0;
      end else if (size0 > 0) begin
        h = mq.pop_front(); popped = 1;
        e_we = h.live && (h.rd != 0); e_addr = h.rd; e_data = h.data;
      end
      if (lv && e_lr) mq.push_back('{live: !(commit && wrd != 0 && lrd == wrd), rd: lrd, data: ld});
      if (popped) m_wait = 0;
      else if (commit && size0 > 0 && m_wait < MAX_WAIT) m_wait++;
      if (e_we) model_rf[e_addr] = e_data;
    end
    if (!e_we) begin e_addr = '0; e_data = '0; end
    exp_q.push_back({e_stall, e_we, e_addr, e_data, e_lr});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
  endtask

  // scoreboard monitor: one expectation per driven cycle, sampled mid-cycle
  always @(negedge clk) begin
    logic [39:0] e, a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {stall_pipe, rf_we, rf_we ? rf_waddr : 5'd0, rf_we ? rf_wdata : 32'd0, L_ready};
      n_cmp++;
      if (a !== e) begin
        n_err++;
        $display("FAIL port_out cyc=%0d act stall=%b we=%b addr=%0d data=%h lready=%b | req stall=%b we=%b addr=%0d data=%h lready=%b",
                 cyc, a[39], a[38], a[37:33], a[32:1], a[0], e[39], e[38], e[37:33], e[32:1], e[0]);
      end
      if (rf_we === 1'b1) dut_rf[rf_waddr] = rf_wdata;
    end
    cyc++;
  end

  initial begin
    n_cmp = 0; n_err = 0; cyc = 0; m_wait = 0;
    for (int i = 0; i < 32; i++) begin model_rf[i] = '0; dut_rf[i] = '0; end
    rst = 1'b1; W_wb_valid = 0; W_rd_index = 0; W_rd_data = 0;
    L_valid = 0; L_rd_index = 0; L_data = 0;

    drive(1, 0, 0, 0, 0, 0, 0);
    drive(1, 1, 5'd3, 32'h1, 1, 5'd4, 32'h2);
    idle(1);

    // single buffered result on an idle pipeline
    drive(0, 0, 0, 0, 1, 5'd5, 32'hDEAD_BEEF);
    idle(3);

    // starvation: pipeline busy, one result forced out after MAX_WAIT lost cycles
    for (int c = 0; c < 10; c++) drive(0, 1, 5'd3, 32'h3000 + c, c == 0, 5'd7, 32'h7777);
    idle(2);

    // full buffer holds off a third result until a slot frees
    for (int c = 0; c < 12; c++) drive(0, 1, 5'd4, 32'h4000 + c, 1, 5'(10 + c % 3), 32'hA000 + c);
    idle(4);

    // write-after-write kill of a buffered result
    drive(0, 1, 5'd2, 32'h2, 1, 5'd9, 32'h1111);
    drive(0, 1, 5'd9, 32'h2222, 0, 0, 0);
    idle(3);
    n_cmp++;
    if (dut_rf[9] !== 32'h2222) begin
      n_err++;
      $display("FAIL waw_x9 act=%h req=%h", dut_rf[9], 32'h2222);
    end

    // x0 targets from both sources
    drive(0, 0, 0, 0, 1, 5'd0, 32'hBAD0);
    idle(1);
    drive(0, 1, 5'd0, 32'h5555, 0, 0, 0);
    idle(1);

    // reset with buffered entries discards them
    drive(0, 1, 5'd1, 32'h11, 1, 5'd20, 32'h2020);
    drive(0, 1, 5'd1, 32'h12, 1, 5'd21, 32'h2121);
    drive(1, 1, 5'd1, 32'h13, 0, 0, 0);
    idle(3);

    // random traffic with a narrow rd range to provoke kills
    for (int c = 0; c < 1500; c++) begin
      drive(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) < 7), 5'($urandom_range(0, 7)),
            $urandom, ($urandom_range(0, 1) == 1), 5'($urandom_range(0, 7)), $urandom);
    end
    idle(MAX_WAIT + DEPTH + 2);

    @(negedge clk);
    @(posedge clk);
    for (int i = 1; i < 32; i++) begin
      n_cmp++;
      if (dut_rf[i] !== model_rf[i]) begin
        n_err++;
        $display("FAIL rf_final x%0d act=%h req=%h", i, dut_rf[i], model_rf[i]);
      end
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL sb_drain act=%0d req=0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/wb_port_arbiter.md
# wb_port_arbiter

- Shares the register file's single write port between two sources:
  - the in-order pipeline write-back result, taken from the WB stage output;
  - results from a long-latency execution unit (multiply/divide, split load).
- Long-latency results are buffered in a small FIFO.
- The pipeline path has priority; a starvation counter forces buffered results out by stalling the pipeline for one cycle.
- Write-after-write ordering is enforced by discarding buffered results that a younger pipeline write has overwritten.

## Interface
Parameters:
- DEPTH, 2: long-latency result FIFO entries (power of two, ≥2)
- MAX_WAIT, 4: consecutive lost arbitration cycles before the FIFO head is forced

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- W_wb_valid  in  1  pipeline WB stage holds an instruction that writes rd
- W_rd_index  in  5  pipeline destination register
- W_rd_data  in  32  pipeline write-back data (WB stage mux output)
- L_valid  in  1  long-latency unit presents a result
- L_rd_index  in  5  long-latency destination register
- L_data  in  32  long-latency result
- L_ready  out  1  FIFO accepts a result this cycle
- stall_pipe  out  1  hold the WB stage; pipeline write not performed this cycle
- rf_we  out  1  register file write enable
- rf_waddr  out  5  register file write address
- rf_wdata  out  32  register file write data

## Operation
- Accept (push): L_valid && L_ready. L_ready = (count < DEPTH) && !rst. A full FIFO does not accept, even if the head pops in the same cycle.
- Pipeline write (P) is committed when W_wb_valid && !stall_pipe.
- Force condition: FIFO non-empty && wait_cnt == MAX_WAIT.
- Per-cycle port grant:
  - If the force condition holds, the FIFO head wins. stall_pipe = W_wb_valid.
  - Else if W_wb_valid, the pipeline wins. rf_* = W_rd_index/W_rd_data.
  - Else if the FIFO is non-empty, the FIFO head wins (pop).
  - Else the port is idle.
- x0: any grant whose address is 0 yields rf_we=0. The grant and pop still occur.
- WAW kill on a committed pipeline write to rd X≠0:
  - every valid FIFO entry with rd X is invalidated (its valid bit is cleared);
  - an incoming result with rd X accepted in the same cycle is pushed already invalid;
  - invalid entries still occupy their slot and pop normally with rf_we=0.
- wait_cnt (saturating at MAX_WAIT):
  - cleared on reset and on any pop;
  - incremented when the FIFO is non-empty and the pipeline wins;
  - holds otherwise.
- Simultaneous push and pop with count<DEPTH: count is unchanged and ordering is preserved.
- Reset: FIFO empty, all valid bits clear, wait_cnt=0.
  - While rst is high, rf_we=0, stall_pipe=0, L_ready=0.
  - Reset mid-operation discards buffered results without writing them.

## Timing
- Pipeline path: 0-cycle latency. rf_* is combinational from W_* in the same cycle.
- Long-latency path: the earliest write is the cycle after the push. Results never bypass the FIFO.
- stall_pipe: combinational from registered state plus W_wb_valid. It lasts exactly one cycle per forced pop; wait_cnt clears in that cycle.
- Worst case for a buffered entry under continuous pipeline writes: written within MAX_WAIT+1 cycles of reaching the head.
- L_ready depends only on registered count. There is no combinational path from L_valid.

## Structure
- Package wb_arb_pkg:
  - wb_req_t struct {logic vld; logic [4:0] rd; logic [31:0] data};
  - constant REG_ZERO = 5'd0;
  - function for the WAW index match.
- Sub-module wb_fifo:
  - DEPTH-entry circular buffer of wb_req_t;
  - push/pop, count, head output;
  - per-entry invalidate-by-rd input.
- Top-level wb_port_arbiter holds the grant logic, the wait_cnt counter and the output mux.

## Test plan
- Idle pipeline, L push {rd=5, data=0xDEAD_BEEF} → L_ready=1; next cycle rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF; FIFO empty after.
- W_wb_valid held high 10 cycles (rd=3), one L result (rd=7) pushed in cycle 0 → pipeline writes cycles 1–4; cycle 5 stall_pipe=1, rf_waddr=7; pipeline rd=3 write resumes cycle 6.
- Push two L results with no pops (FIFO full) → L_ready=0. A third L_valid is held off until the cycle after a pop.
- FIFO holds {rd=9, 0x1111}; pipeline commits rd=9 0x2222 → later pop of that entry has rf_we=0; final x9=0x2222.
- L result rd=0 popped → rf_we=0, count decrements. Pipeline W_rd_index=0 → rf_we=0, no stall.
- Assert rst for 1 cycle with 2 entries buffered → count=0, wait_cnt=0, no rf write of those entries; L_ready=1 the cycle after rst deasserts.
